// File: rtl/game_pkg.sv
// Shared game constants, FSM state type and small geometry helpers.
//   SCREEN_W/H    : visible area in pixels
//   *_SIZE, *_W/H : sprite box sizes in pixels
//   LFSR_SEED     : LFSR value loaded on reset
package game_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned ENEMY_SIZE  = 20;
  localparam int unsigned PLAYER_SIZE = 20;
  localparam int unsigned BULLET_W    = 5;
  localparam int unsigned BULLET_H    = 10;
  localparam int unsigned SPAWN_X0    = 64;
  localparam int unsigned SPAWN_Y0    = 32;
  localparam int unsigned COORD_W     = 10;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIT   = 2'd1,
    MOVE  = 2'd2,
    SPAWN = 2'd3
  } state_e;

  // Half-open 1-D overlap of [a, a+a_len) and [b, b+b_len); 11-bit math avoids wrap.
  function automatic logic span_overlap(input logic [COORD_W-1:0] a, input int unsigned a_len,
                                        input logic [COORD_W-1:0] b, input int unsigned b_len);
    logic [COORD_W:0] a_end;
    logic [COORD_W:0] b_end;
    a_end = 11'(a) + 11'(a_len);
    b_end = 11'(b) + 11'(b_len);
    return (11'(a) < b_end) && (11'(b) < a_end);
  endfunction

  // Move pos toward tgt by at most step, landing exactly on tgt rather than overshooting.
  function automatic logic [COORD_W-1:0] step_toward(input logic [COORD_W-1:0] pos,
                                                     input logic [COORD_W-1:0] tgt,
                                                     input logic [COORD_W-1:0] step);
    if (pos < tgt) return ((tgt - pos) > step) ? pos + step : tgt;
    if (pos > tgt) return ((pos - tgt) > step) ? pos - step : tgt;
    return pos;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; advances every clock outside reset.
//   clk  : clock
//   rst  : async active-high reset, loads seed
//   seed : reset value
//   q    : current LFSR state
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= seed;
    else     q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/enemy_manager.sv
// Enemy slot manager: per-frame hit test, chase movement, LFSR spawning, sprite pixel.
//   clk_25, rst        : pixel clock, async active-high reset
//   frame_tick         : start-of-vblank pulse, starts frame processing
//   player_x/y         : player top-left
//   bullet_active/x/y  : bullet state and top-left
//   h_cnt, v_cnt       : scan position
//   pixel_on           : registered, an alive enemy covers the scan position
//   bullet_kill        : one-cycle pulse per bullet kill
//   player_hit         : one-cycle pulse per enemy touching the player
//   alive_mask         : slot alive bits
//   score              : saturating kill count
module enemy_manager
  import game_pkg::*;
#(
  parameter int unsigned N_SLOTS      = 4,
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter int unsigned MOVE_DIV     = 2,
  parameter int unsigned STEP         = 1
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [9:0]         player_x,
  input  logic [9:0]         player_y,
  input  logic               bullet_active,
  input  logic [9:0]         bullet_x,
  input  logic [9:0]         bullet_y,
  input  logic [9:0]         h_cnt,
  input  logic [9:0]         v_cnt,
  output logic               pixel_on,
  output logic               bullet_kill,
  output logic               player_hit,
  output logic [N_SLOTS-1:0] alive_mask,
  output logic [7:0]         score
);

  localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int unsigned SP_W  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam int unsigned MV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N_SLOTS-1:0] alive_q;
  logic [9:0]         x_q [N_SLOTS];
  logic [9:0]         y_q [N_SLOTS];
  logic [SP_W-1:0]    spawn_cnt_q;
  logic [MV_W-1:0]    move_cnt_q;
  logic               kill_done_q;
  logic [7:0]         score_q;
  logic               pixel_q;
  logic               bullet_kill_q;
  logic               player_hit_q;
  logic [15:0]        lfsr_q;

  logic [9:0]       cur_x_c, cur_y_c;
  logic             bul_ovl_c, ply_ovl_c, last_slot_c;
  logic             move_now_c, spawn_now_c;
  logic             free_found_c;
  logic [IDX_W-1:0] free_idx_c;
  logic             cover_c;
  logic [9:0]       step_x_d, step_y_d, spawn_x_d, spawn_y_d;

  lfsr16 u_lfsr (
    .clk  (clk_25),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  assign pixel_on    = pixel_q;
  assign bullet_kill = bullet_kill_q;
  assign player_hit  = player_hit_q;
  assign alive_mask  = alive_q;
  assign score       = score_q;

  // Geometry of the slot currently being visited.
  always_comb begin
    cur_x_c     = x_q[idx_q];
    cur_y_c     = y_q[idx_q];
    // kill_done_q gates the bullet so only the lowest-index overlap is killed.
    bul_ovl_c   = bullet_active && !kill_done_q &&
                  span_overlap(bullet_x, BULLET_W, cur_x_c, ENEMY_SIZE) &&
                  span_overlap(bullet_y, BULLET_H, cur_y_c, ENEMY_SIZE);
    ply_ovl_c   = span_overlap(player_x, PLAYER_SIZE, cur_x_c, ENEMY_SIZE) &&
                  span_overlap(player_y, PLAYER_SIZE, cur_y_c, ENEMY_SIZE);
    last_slot_c = (idx_q == IDX_W'(N_SLOTS - 1));
    move_now_c  = (move_cnt_q == MV_W'(MOVE_DIV - 1));
    spawn_now_c = (spawn_cnt_q == SP_W'(SPAWN_PERIOD - 1));
    step_x_d    = step_toward(cur_x_c, player_x, 10'(STEP));
    step_y_d    = step_toward(cur_y_c, player_y, 10'(STEP));
    spawn_x_d   = 10'(lfsr_q[8:0]) + 10'(SPAWN_X0);
    spawn_y_d   = 10'(lfsr_q[15:8]) + 10'(SPAWN_Y0);
  end

  // Lowest-index free slot (descending scan so the lowest index wins).
  always_comb begin
    free_found_c = 1'b0;
    free_idx_c   = '0;
    for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
      if (!alive_q[i]) begin
        free_found_c = 1'b1;
        free_idx_c   = IDX_W'(i);
      end
    end
  end

  // Sprite coverage of the current scan position.
  always_comb begin
    cover_c = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (alive_q[i] && span_overlap(h_cnt, 1, x_q[i], ENEMY_SIZE) &&
          span_overlap(v_cnt, 1, y_q[i], ENEMY_SIZE))
        cover_c = 1'b1;
    end
  end

  // Frame-processing FSM and slot state.
  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      alive_q       <= '0;
      spawn_cnt_q   <= '0;
      move_cnt_q    <= '0;
      kill_done_q   <= 1'b0;
      score_q       <= '0;
      pixel_q       <= 1'b0;
      bullet_kill_q <= 1'b0;
      player_hit_q  <= 1'b0;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      bullet_kill_q <= 1'b0;
      player_hit_q  <= 1'b0;
      pixel_q       <= cover_c;
      case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_q     <= HIT;
            idx_q       <= '0;
            kill_done_q <= 1'b0;
          end
        end
        HIT: begin
          if (alive_q[idx_q]) begin
            // Bullet takes priority when a slot meets both conditions.
            if (bul_ovl_c) begin
              alive_q[idx_q] <= 1'b0;
              bullet_kill_q  <= 1'b1;
              kill_done_q    <= 1'b1;
              score_q        <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            end else if (ply_ovl_c) begin
              alive_q[idx_q] <= 1'b0;
              player_hit_q   <= 1'b1;
            end
          end
          if (last_slot_c) begin
            state_q <= MOVE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        MOVE: begin
          if (move_now_c && alive_q[idx_q]) begin
            x_q[idx_q] <= step_x_d;
            y_q[idx_q] <= step_y_d;
          end
          if (last_slot_c) begin
            state_q <= SPAWN;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        SPAWN: begin
          if (spawn_now_c && free_found_c) begin
            alive_q[free_idx_c] <= 1'b1;
            x_q[free_idx_c]     <= spawn_x_d;
            y_q[free_idx_c]     <= spawn_y_d;
          end
          // Both frame counters wrap every frame regardless of activity.
          spawn_cnt_q <= spawn_now_c ? '0 : spawn_cnt_q + SP_W'(1);
          move_cnt_q  <= move_now_c ? '0 : move_cnt_q + MV_W'(1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_manager.sv
// Directed bench for enemy_manager: dut_a uses default parameters, dut_b spawns and moves every frame.
module tb_enemy_manager;

  localparam int FRAME_CYC = 9;   // 2*N_SLOTS+1 with N_SLOTS=4

  logic       clk_25;
  logic       rst_a, rst_b, tick_a, tick_b;
  logic [9:0] player_x, player_y, bullet_x, bullet_y, h_cnt, v_cnt;
  logic       bullet_active;
  logic       pix_a, bk_a, ph_a, pix_b, bk_b, ph_b;
  logic [3:0] mask_a, mask_b;
  logic [7:0] score_a, score_b;

  enemy_manager u_a (
    .clk_25(clk_25), .rst(rst_a), .frame_tick(tick_a),
    .player_x(player_x), .player_y(player_y),
    .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pixel_on(pix_a), .bullet_kill(bk_a), .player_hit(ph_a),
    .alive_mask(mask_a), .score(score_a)
  );

  enemy_manager #(.SPAWN_PERIOD(1), .MOVE_DIV(1)) u_b (
    .clk_25(clk_25), .rst(rst_b), .frame_tick(tick_b),
    .player_x(player_x), .player_y(player_y),
    .bullet_active(bullet_active), .bullet_x(bullet_x), .bullet_y(bullet_y),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .pixel_on(pix_b), .bullet_kill(bk_b), .player_hit(ph_b),
    .alive_mask(mask_b), .score(score_b)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed ACE1.
  logic [15:0] lfsr_a, lfsr_b;
  always @(posedge clk_25 or posedge rst_a)
    if (rst_a) lfsr_a <= 16'hACE1;
    else       lfsr_a <= {lfsr_a[14:0], lfsr_a[15] ^ lfsr_a[13] ^ lfsr_a[12] ^ lfsr_a[10]};
  always @(posedge clk_25 or posedge rst_b)
    if (rst_b) lfsr_b <= 16'hACE1;
    else       lfsr_b <= {lfsr_b[14:0], lfsr_b[15] ^ lfsr_b[13] ^ lfsr_b[12] ^ lfsr_b[10]};

  int kill_cnt = 0;
  int hit_cnt  = 0;
  always @(negedge clk_25) begin
    if (bk_b) kill_cnt++;
    if (ph_b) hit_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int mask_hit0, mask_pre, fr_kills, fr_hits, sp_x, sp_y;

  typedef struct { int px; int py; int exp_mask; } spawn_vec_t;
  typedef struct { int dx; int dy; int exp_pix; } probe_vec_t;
  spawn_vec_t sv [6];
  probe_vec_t pv [7];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int in_box(input int ex, input int ey, input int x, input int y);
    return (x >= ex && x < ex + 20 && y >= ey && y < ey + 20) ? 1 : 0;
  endfunction

  // One full frame; records mask after slot 0's hit test, mask before the spawn edge,
  // pulse counts and the spawn position predicted from the reference LFSR.
  task automatic run_frame(input bit sel_b, input bit dbl);
    int k0, h0;
    logic [15:0] lf;
    k0 = kill_cnt;
    h0 = hit_cnt;
    @(negedge clk_25);
    if (sel_b) tick_b = 1'b1; else tick_a = 1'b1;
    @(posedge clk_25); #1;
    for (int c = 1; c <= FRAME_CYC; c++) begin
      @(negedge clk_25);
      tick_a = 1'b0;
      tick_b = sel_b && dbl && (c == 2);
      @(posedge clk_25); #1;
      if (c == 1) mask_hit0 = sel_b ? int'(mask_b) : int'(mask_a);
      if (c == FRAME_CYC - 1) begin
        lf       = sel_b ? lfsr_b : lfsr_a;
        mask_pre = sel_b ? int'(mask_b) : int'(mask_a);
        sp_x     = 64 + int'(lf[8:0]);
        sp_y     = 32 + int'(lf[15:8]);
      end
    end
    fr_kills = kill_cnt - k0;
    fr_hits  = hit_cnt - h0;
  endtask

  task automatic probe(input bit sel_b, input int x, input int y, output int pix);
    @(negedge clk_25);
    h_cnt = 10'(x);
    v_cnt = 10'(y);
    @(posedge clk_25); #1;
    pix = sel_b ? int'(pix_b) : int'(pix_a);
  endtask

  task automatic reset_b();
    @(negedge clk_25); rst_b = 1'b1;
    @(negedge clk_25); rst_b = 1'b0;
  endtask

  initial begin
    int pix, p0x, p0y, kills;

    sv[0] = '{0, 460, 1};   sv[1] = '{0, 460, 3};   sv[2] = '{620, 460, 7};
    sv[3] = '{620, 460, 15}; sv[4] = '{0, 460, 15}; sv[5] = '{300, 460, 15};
    pv[0] = '{0, 0, 1};  pv[1] = '{19, 19, 1}; pv[2] = '{-1, 0, 0}; pv[3] = '{0, -1, 0};
    pv[4] = '{20, 0, 0}; pv[5] = '{0, 20, 0};  pv[6] = '{10, 10, 1};

    rst_a = 1'b1; rst_b = 1'b1; tick_a = 1'b0; tick_b = 1'b0;
    player_x = 10'd320; player_y = 10'd240;
    bullet_active = 1'b0; bullet_x = '0; bullet_y = '0; h_cnt = '0; v_cnt = '0;
    repeat (2) @(posedge clk_25);
    #1;
    check("reset_mask", int'(mask_a), 0);
    check("reset_score", int'(score_b), 0);
    check("reset_pulses", int'({bk_a, ph_a, pix_a, bk_b, ph_b, pix_b}), 0);
    @(negedge clk_25); rst_a = 1'b0; rst_b = 1'b0;

    // Default parameters: first spawn lands on the 60th frame.
    for (int f = 1; f <= 59; f++) run_frame(1'b0, 1'b0);
    check("a_mask_f59", int'(mask_a), 0);
    run_frame(1'b0, 1'b0);
    check("a_mask_pre_spawn", mask_pre, 0);
    check("a_mask_f60", int'(mask_a), 1);
    foreach (pv[i]) begin
      probe(1'b0, sp_x + pv[i].dx, sp_y + pv[i].dy, pix);
      check($sformatf("a_pix_%0d", i), pix, pv[i].exp_pix);
    end

    // Spawn every frame until the slots are full.
    reset_b();
    foreach (sv[i]) begin
      player_x = 10'(sv[i].px);
      player_y = 10'(sv[i].py);
      run_frame(1'b1, 1'b0);
      check($sformatf("b_fill_mask_%0d", i), int'(mask_b), sv[i].exp_mask);
      check($sformatf("b_fill_evt_%0d", i), fr_kills + fr_hits + int'(score_b), 0);
    end

    // Inactive bullet on the enemy does nothing.
    reset_b();
    player_x = 10'd0; player_y = 10'd460;
    run_frame(1'b1, 1'b0);
    bullet_x = 10'(sp_x); bullet_y = 10'(sp_y); bullet_active = 1'b0;
    run_frame(1'b1, 1'b0);
    check("b_nokill_pulses", fr_kills, 0);
    check("b_nokill_mask", int'(mask_b), 3);

    // Bullet kills, then repeated kills saturate the score.
    reset_b();
    run_frame(1'b1, 1'b0);
    bullet_x = 10'(sp_x); bullet_y = 10'(sp_y); bullet_active = 1'b1;
    run_frame(1'b1, 1'b0);
    check("b_kill_pulses", fr_kills, 1);
    check("b_kill_mid_mask", mask_hit0 & 1, 0);
    check("b_kill_score", int'(score_b), 1);
    check("b_kill_respawn", int'(mask_b), 1);
    kills = 0;
    for (int k = 2; k <= 256; k++) begin
      bullet_x = 10'(sp_x); bullet_y = 10'(sp_y);
      run_frame(1'b1, 1'b0);
      kills += fr_kills;
      if (k == 255) check("b_score_255", int'(score_b), 255);
    end
    check("b_kill_total", kills, 255);
    check("b_score_sat", int'(score_b), 255);
    bullet_active = 1'b0;

    // A second tick during HIT must not start another frame.
    run_frame(1'b1, 1'b1);
    repeat (30) @(posedge clk_25);
    #1;
    check("b_dbl_tick_mask", int'(mask_b), 3);

    // Reset mid-MOVE clears everything at once.
    probe(1'b1, sp_x + 5, sp_y + 5, pix);
    check("b_pre_rst_pix", pix, 1);
    @(negedge clk_25); tick_b = 1'b1;
    @(posedge clk_25); #1; tick_b = 1'b0;
    repeat (5) @(posedge clk_25);
    #5 rst_b = 1'b1;
    #1;
    check("b_rst_mask", int'(mask_b), 0);
    check("b_rst_score", int'(score_b), 0);
    check("b_rst_outs", int'({bk_b, ph_b, pix_b}), 0);
    @(negedge clk_25); rst_b = 1'b0;

    // Chase one step, then touch the player.
    run_frame(1'b1, 1'b0);
    check("b_post_rst_mask", int'(mask_b), 1);
    p0x = sp_x; p0y = sp_y;
    player_x = 10'(p0x + 20); player_y = 10'(p0y);
    run_frame(1'b1, 1'b0);
    check("b_touch_no_hit", fr_hits, 0);
    probe(1'b1, p0x + 1, p0y, pix);
    check("b_move_new_left", pix, 1);
    probe(1'b1, p0x + 20, p0y, pix);
    check("b_move_new_right", pix, 1);
    probe(1'b1, p0x, p0y, pix);
    check("b_move_old_left", pix, in_box(sp_x, sp_y, p0x, p0y));
    run_frame(1'b1, 1'b0);
    check("b_player_hit", (fr_hits > 0) ? 1 : 0, 1);
    check("b_hit_mid_mask", mask_hit0 & 1, 0);
    check("b_hit_score", int'(score_b), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enemy_manager.md
ENEMY_MANAGER -- requirements
Module: enemy_manager

Interface
REQ-001 The block SHALL have parameter N_SLOTS, default 4: number of enemy slots (1..8).
REQ-002 The block SHALL have parameter SPAWN_PERIOD, default 60: frames between spawn attempts.
REQ-003 The block SHALL have parameter MOVE_DIV, default 2: frames between enemy moves.
REQ-004 The block SHALL have parameter STEP, default 1: pixels moved per axis per move.
REQ-005 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_25  in  1  25 MHz pixel clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- player_x, player_y  in  10 each  player top-left
- bullet_active  in  1  bullet in flight
- bullet_x, bullet_y  in  10 each  bullet top-left
- h_cnt, v_cnt  in  10 each  VGA scan position
- pixel_on  out  1  an alive enemy covers (h_cnt, v_cnt), registered
- bullet_kill  out  1  one-cycle pulse: bullet destroyed an enemy
- player_hit  out  1  one-cycle pulse: enemy touched player
- alive_mask  out  N_SLOTS  bit i = slot i alive
- score  out  8  kills, saturating

Function
REQ-006 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk_25 cycle except in reset.
REQ-007 The FSM SHALL have states IDLE, HIT, MOVE, SPAWN; frame_tick SHALL be honoured only in IDLE and SHALL move IDLE->HIT.
REQ-008 HIT SHALL visit one slot per cycle, slots 0..N_SLOTS-1, then go to MOVE.
REQ-009 In HIT, an alive slot overlapping the bullet (5x10 box vs 20x20 enemy, half-open intervals) while bullet_active=1 SHALL be cleared, pulse bullet_kill and increment score (held at 255); at most one kill per frame (lowest index wins).
REQ-010 In HIT, an alive slot overlapping the player (20x20 vs 20x20) SHALL be cleared and pulse player_hit; a slot meeting both conditions SHALL count as a bullet kill only.
REQ-011 MOVE SHALL visit one slot per cycle; on frames where move_cnt = MOVE_DIV-1, each alive slot SHALL step STEP pixels toward player per axis (no step on an axis if equal; never overshoot).
REQ-012 SPAWN SHALL take one cycle; on frames where spawn_cnt = SPAWN_PERIOD-1, the lowest-index free slot SHALL become alive at x = 64 + lfsr[8:0], y = 32 + lfsr[15:8]; if no slot is free, the spawn SHALL be skipped silently.
REQ-013 spawn_cnt and move_cnt SHALL count frames modulo their period and SHALL wrap whether or not a spawn or move occurred.
REQ-014 SPAWN SHALL return to IDLE; frame processing latency SHALL be 2*N_SLOTS+1 cycles after frame_tick.
REQ-015 pixel_on SHALL be registered, 1-cycle latency from h_cnt/v_cnt, using a 20x20 box per alive slot.
REQ-016 Slot positions SHALL change only during frame processing, never mid visible scan.

Reset
REQ-017 On rst, the block SHALL clear all slots, zero score, spawn_cnt and move_cnt, set state IDLE, load LFSR with 16'hACE1 and drive all outputs 0; assertion mid-frame-processing SHALL abort processing immediately.

Structure
REQ-018 Package game_pkg SHALL hold SCREEN_W=640, SCREEN_H=480, ENEMY_SIZE=20, PLAYER_SIZE=20, BULLET_W=5, BULLET_H=10, LFSR_SEED, and the FSM state enum.
REQ-019 The LFSR SHALL be a separate sub-module lfsr16 (clk, rst, seed, q).

Verification
REQ-020 Reset, then 60 frame_ticks, player at (320,240): after tick 60 plus 9 cycles, alive_mask=0001 and slot0 position matches the reference LFSR model.
REQ-021 Spawn with SPAWN_PERIOD=1 for 6 frames: alive_mask=1111 after frame 4; frames 5-6 leave mask unchanged with no other change.
REQ-022 Bullet placed on the slot0 top-left with bullet_active=1, then frame_tick: one bullet_kill pulse, alive_mask bit0=0, score=1; bullet_active=0 -> no kill.
REQ-023 Enemy at (300,240), player at (320,240), STEP=1, MOVE_DIV=1: x reaches 301 after one frame; overlap -> player_hit pulse, slot cleared, score unchanged.
REQ-024 Score preloaded to 255 by repeated kills, another kill -> score stays 255; frame_tick during HIT ignored; rst asserted mid-MOVE -> all outputs 0 next cycle.
